trigger_stop_ctrl: RTL

TRIGGER_STOP_CTRL -- requirements
Module: trigger_stop_ctrl

---
 rtl/trig_pkg.sv | 21 ++
 rtl/trigger_stop_ctrl_if.sv | 35 +++
 rtl/trig_match.sv | 44 ++++
 rtl/trigger_stop_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types and defaults for the trigger/stop controller: FSM state
// encoding, trigger mode codes and parameter defaults.
package trig_pkg;

    localparam int N_CH_DEF          = 8;
    localparam int HOLDOFF_WIDTH_DEF = 16;
    localparam int COUNT_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_STOPPED = 2'd3
    } trig_state_e;

    localparam logic [1:0] MODE_LEVEL      = 2'b00;
    localparam logic [1:0] MODE_MATCH_RISE = 2'b01;
    localparam logic [1:0] MODE_MATCH_FALL = 2'b10;
    localparam logic [1:0] MODE_ANY_CHANGE = 2'b11;

endpackage

// File: rtl/trigger_stop_ctrl_if.sv
// Signal bundle between the capture front end (master) and the trigger/stop
// controller (slave).
interface trigger_stop_ctrl_if
    import trig_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
    parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
);
    // No valid/ready pair: every input is level-sampled on each rising clk
    // edge, except i_rearm, a one-cycle pulse acted on at the edge it is seen.
    logic                     primed;
    logic [N_CH-1:0]          i_data;
    logic [N_CH-1:0]          i_mask;
    logic [N_CH-1:0]          i_value;
    logic [1:0]               i_mode;
    logic [COUNT_WIDTH-1:0]   i_count;
    logic [HOLDOFF_WIDTH-1:0] i_holdoff;
    logic                     i_rearm;
    logic [1:0]               o_state;
    logic                     triggered;
    logic                     stopped;
    logic [HOLDOFF_WIDTH-1:0] o_holdoff_cnt;

    modport master (
        output primed, i_data, i_mask, i_value, i_mode, i_count, i_holdoff, i_rearm,
        input  o_state, triggered, stopped, o_holdoff_cnt
    );

    modport slave (
        input  primed, i_data, i_mask, i_value, i_mode, i_count, i_holdoff, i_rearm,
        output o_state, triggered, stopped, o_holdoff_cnt
    );

endinterface

// File: rtl/trig_match.sv
// Masked pattern compare plus one-cycle history, producing the per-cycle
// trigger event for the selected mode.
module trig_match
    import trig_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_data,
    input  logic [N_CH-1:0] i_mask,
    input  logic [N_CH-1:0] i_value,
    input  logic [1:0]      i_mode,
    output logic            evt
);
    logic            match;
    logic            prev_match;
    logic [N_CH-1:0] prev_data;

    assign match = (((i_data ^ i_value) & i_mask) == '0);

    // History runs in every state so edge modes see a valid previous cycle on arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_match <= 1'b0;
            prev_data  <= '0;
        end else begin
            prev_match <= match;
            prev_data  <= i_data;
        end
    end

    always_comb begin
        evt = 1'b0;
        case (i_mode)
            MODE_LEVEL:      evt = match;
            MODE_MATCH_RISE: evt = match & ~prev_match;
            MODE_MATCH_FALL: evt = ~match & prev_match;
            MODE_ANY_CHANGE: evt = |((i_data ^ prev_data) & i_mask);
            default:         evt = 1'b0;
        endcase
    end

endmodule

// File: rtl/trigger_stop_ctrl.sv
// Logic-analyzer trigger/stop sequencer: counts trigger events while armed,
// then runs a post-trigger holdoff before telling capture to stop.
module trigger_stop_ctrl
    import trig_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF,
    parameter int COUNT_WIDTH   = COUNT_WIDTH_DEF
) (
    input logic                clk,
    input logic                reset,
    trigger_stop_ctrl_if.slave bus
);
    trig_state_e              state_q, state_d;
    logic [COUNT_WIDTH-1:0]   occ_q, occ_d;
    logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
    logic                     evt;
    logic [COUNT_WIDTH-1:0]   need;
    logic [COUNT_WIDTH:0]     occ_inc;
    logic                     hit;

    trig_match #(.N_CH(N_CH)) u_match (
        .clk     (clk),
        .reset   (reset),
        .i_data  (bus.i_data),
        .i_mask  (bus.i_mask),
        .i_value (bus.i_value),
        .i_mode  (bus.i_mode),
        .evt     (evt)
    );

    // One bit wider so the compare still works once occ is saturated.
    assign need    = (bus.i_count == '0) ? COUNT_WIDTH'(1) : bus.i_count;
    assign occ_inc = {1'b0, occ_q} + (COUNT_WIDTH + 1)'(1);
    assign hit     = (occ_inc >= {1'b0, need});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            occ_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        hcnt_d  = hcnt_q;
        if (bus.i_rearm) begin
            state_d = ST_IDLE;
            occ_d   = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    occ_d  = '0;
                    hcnt_d = '0;
                    if (bus.primed) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!bus.primed) begin
                        state_d = ST_IDLE;
                        occ_d   = '0;
                    end else if (evt) begin
                        if (occ_q != '1) occ_d = occ_q + COUNT_WIDTH'(1);
                        if (hit) begin
                            state_d = ST_HOLDOFF;
                            hcnt_d  = '0;
                        end
                    end
                end
                // >= rather than == so a holdoff lowered below hcnt still stops.
                ST_HOLDOFF: begin
                    if (hcnt_q >= bus.i_holdoff) state_d = ST_STOPPED;
                    else                         hcnt_d  = hcnt_q + HOLDOFF_WIDTH'(1);
                end
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_state       = state_q;
        bus.triggered     = (state_q == ST_HOLDOFF) || (state_q == ST_STOPPED);
        bus.stopped       = (state_q == ST_STOPPED);
        bus.o_holdoff_cnt = hcnt_q;
    end

endmodule
